vga_sync_receiver: RTL and testbench
====================================

// Module: vga_sync_receiver
// PURPOSE
//  Sink end of the VGA timing interface: samples SYNC_H/SYNC_V/SYNC_BLANK (+RGB) on the
//  pixel clock, recovers active-pixel coordinates, measures line/frame lengths and
//  declares lock once timing matches the expected mode. Used as an on-chip monitor
//  on the display path and as the checker for our sync generator.
// PARAMETERS
//  HTOTAL      800  expected clocks per line (hsync fall to hsync fall)
//  VTOTAL      525  expected lines per frame (vsync fall to vsync fall)
//  LOCK_FRAMES 2    consecutive good frames required to enter LOCKED (1..15)
// PORTS
//  clk          in   1   pixel clock; all logic on rising edge
//  rst          in   1   synchronous reset, active-low
//  SYNC_H       in   1   horizontal sync, active-low
//  SYNC_V       in   1   vertical sync, active-low
//  SYNC_BLANK   in   1   1 = active video, 0 = blanking
//  Red/Green/Blue in 8 each  pixel data, qualified by SYNC_BLANK
//  x            out  10  active pixel column of current pixel_valid
//  y            out  10  active line index of current pixel_valid
//  pixel_valid  out  1   x/y/pix_* valid this cycle
//  pix_r/g/b    out  8 each  registered RGB aligned with pixel_valid
//  frame_start  out  1   1-cycle pulse on each vsync falling edge
//  locked       out  1   timing matches HTOTAL/VTOTAL
//  h_meas       out  10  length of last completed line (clocks)
//  v_meas       out  10  length of last completed frame (lines)
//  sync_err     out  1   1-cycle pulse on bad line/frame while LOCKED
//  err_count    out  8   saturating count of sync_err pulses
// BEHAVIOUR
//  Reset (rst=0 at edge): all outputs 0, FSM=SEARCH, counters 0, input regs =1 (idle).
//  Inputs registered once; edges from reg vs previous reg: hs_fall, vs_fall.
//  Latency: pixel_valid/x/y/pix_* appear 2 clk after the input sample they describe.
//  hcnt: +1 per clk, saturates at 1023; on hs_fall h_meas<=hcnt+1, hcnt<=0.
//   hcnt reaching 1023 with no hs_fall = bad line (missing hsync).
//  lcnt: +1 on hs_fall without vs_fall. On vs_fall: v_meas<=lcnt+hs_fall, lcnt<=0
//   (coincident hs/vs edge counts as line 0 of new frame). lcnt saturates at 1023.
//  x: 0 at hs_fall; each cycle with SYNC_BLANK=1 emits pixel_valid with x, then x+1.
//   x stops at 1023 (no wrap). y: 0 at vs_fall; at hs_fall, +1 if previous line had
//   any active pixel (line_active flag, cleared at hs_fall). vs_fall wins over hs_fall.
//  Good line: h_meas==HTOTAL. Good frame: all lines good and v_meas==VTOTAL.
//  FSM:
//   SEARCH  -> WAIT_V on first hs_fall.
//   WAIT_V  -> LOCKING on vs_fall (good_cnt<=0); frame measurement starts here.
//   LOCKING : bad line -> WAIT_V; vs_fall with good frame -> good_cnt+1;
//             good_cnt==LOCK_FRAMES -> LOCKED; vs_fall bad frame -> good_cnt<=0.
//   LOCKED  : locked=1; bad line or bad frame -> SEARCH, sync_err pulse,
//             err_count+1 (sat 255), locked<=0 same edge.
//  locked only changes on an hs_fall/vs_fall/overflow event; pixel_valid, x, y, h_meas,
//  v_meas, frame_start operate in every state (not gated by locked).
//  Reset mid-frame: everything returns to reset values; relock requires fresh frames.
//  SYNC_BLANK=1 while SYNC_H/SYNC_V low: still reported as valid pixels (no filtering).
// TESTING
//  1 640x480 stream (800x525, 640x480 active) 4 frames -> locked rises at vs_fall ending
//    frame 2 after WAIT_V; h_meas=800, v_meas=525; 307200 pixel_valid per frame.
//  2 First active pixel of a frame -> x=0,y=0,pix_* = driven RGB, 2 clk after sample;
//    last -> x=639,y=479.
//  3 While LOCKED, one line of 799 clocks -> sync_err 1 pulse, err_count=1, locked=0,
//    FSM SEARCH; relock after 2 further good frames.
//  4 Hold SYNC_H high 1100 clocks while LOCKED -> hcnt saturates 1023, sync_err, SEARCH.
//  5 vsync fall coincident vs offset 16 clk from hs_fall -> v_meas=525 both cases.
//  6 rst=0 one cycle mid-line while LOCKED -> all outputs 0 next cycle; err_count=0.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//   Sink end of a VGA timing interface. Registers SYNC_H/SYNC_V/SYNC_BLANK and
//   RGB once, then recovers active-pixel coordinates and measures line and frame
//   lengths. It declares lock once the timing has matched HTOTAL/VTOTAL for
//   LOCK_FRAMES consecutive frames.
//
// Ports
//   clk                   pixel clock, rising edge
//   rst                   synchronous reset, active low
//   SYNC_H, SYNC_V        active-low syncs
//   SYNC_BLANK            1 = active video
//   Red/Green/Blue [7:0]  pixel data qualified by SYNC_BLANK
//   x, y [9:0]            coordinates of the pixel flagged by pixel_valid
//   pixel_valid           x/y/pix_* valid this cycle (2 clk after the input sample)
//   pix_r/g/b [7:0]       RGB aligned with pixel_valid
//   frame_start           1-cycle pulse per vsync falling edge
//   locked                timing matches the expected mode
//   h_meas, v_meas [9:0]  last completed line length (clk) / frame length (lines)
//   sync_err              1-cycle pulse on a bad line/frame while locked
//   err_count [7:0]       saturating count of sync_err pulses
module vga_sync_receiver #(
  parameter int HTOTAL      = 800,
  parameter int VTOTAL      = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SYNC_H,
  input  logic       SYNC_V,
  input  logic       SYNC_BLANK,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic [7:0] pix_r,
  output logic [7:0] pix_g,
  output logic [7:0] pix_b,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_meas,
  output logic [9:0] v_meas,
  output logic       sync_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {SEARCH, WAIT_V, LOCKING, LOCKED} state_t;

  localparam logic [9:0] CNT_MAX = 10'h3FF;

  // input capture and edge history
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  // timing counters
  logic [9:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [9:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
  logic       line_active_q, line_active_d;
  // FSM
  state_t     state_q, state_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  // outputs
  logic [9:0] x_q, x_d, y_q, y_d, h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic       pv_q, pv_d, fs_q, fs_d, locked_q, locked_d, sync_err_q, sync_err_d;
  logic [7:0] pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic [7:0] err_count_q, err_count_d;

  // combinational helpers
  logic       hs_fall, vs_fall, h_ovf, bad_line, frame_good, frame_bad;
  logic [9:0] h_len, l_len, x_cur, y_cur;

  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;

  // Clocks in the line ending now (saturating), also the next hcnt value.
  assign h_len = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1;
  // Fires exactly once, on the cycle hcnt reaches its ceiling without an hsync.
  assign h_ovf = ~hs_fall && (hcnt_q == CNT_MAX - 10'd1);
  // Lines in the frame including one ending on this cycle; a coincident hs/vs
  // edge closes the old frame's last line and starts line 0 of the new one.
  assign l_len = (hs_fall && lcnt_q != CNT_MAX) ? lcnt_q + 10'd1 : lcnt_q;

  assign bad_line   = (hs_fall && h_len != 10'(HTOTAL)) || h_ovf;
  assign frame_good = vs_fall && !bad_line && l_len == 10'(VTOTAL);
  assign frame_bad  = vs_fall && l_len != 10'(VTOTAL);

  assign x_cur = hs_fall ? 10'd0 : xcnt_q;
  assign y_cur = vs_fall ? 10'd0 :
                 (hs_fall && line_active_q && ycnt_q != CNT_MAX) ? ycnt_q + 10'd1 : ycnt_q;

  always_comb begin
    hs_d      = SYNC_H;
    vs_d      = SYNC_V;
    blank_d   = SYNC_BLANK;
    r_d       = Red;
    g_d       = Green;
    b_d       = Blue;
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;

    hcnt_d   = hs_fall ? 10'd0 : h_len;
    h_meas_d = hs_fall ? h_len : h_meas_q;
    lcnt_d   = vs_fall ? 10'd0 : l_len;
    v_meas_d = vs_fall ? l_len : v_meas_q;

    // Pixel path: x/y/pix hold their last values when no pixel is valid.
    xcnt_d        = x_cur;
    ycnt_d        = y_cur;
    line_active_d = (hs_fall ? 1'b0 : line_active_q) | blank_q;
    pv_d          = blank_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_r_d       = pix_r_q;
    pix_g_d       = pix_g_q;
    pix_b_d       = pix_b_q;
    if (blank_q) begin
      x_d     = x_cur;
      y_d     = y_cur;
      pix_r_d = r_q;
      pix_g_d = g_q;
      pix_b_d = b_q;
      if (x_cur != CNT_MAX) xcnt_d = x_cur + 10'd1;
    end
    fs_d = vs_fall;

    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    sync_err_d  = 1'b0;
    err_count_d = err_count_q;
    case (state_q)
      SEARCH:  if (hs_fall) state_d = WAIT_V;
      WAIT_V:  if (vs_fall) begin
                 state_d    = LOCKING;
                 good_cnt_d = 4'd0;
               end
      LOCKING: if (bad_line) begin
                 state_d = WAIT_V;
               end else if (frame_good) begin
                 good_cnt_d = good_cnt_q + 4'd1;
                 if (good_cnt_q + 4'd1 == 4'(LOCK_FRAMES)) state_d = LOCKED;
               end else if (vs_fall) begin
                 good_cnt_d = 4'd0;
               end
      LOCKED:  if (bad_line || frame_bad) begin
                 state_d    = SEARCH;
                 sync_err_d = 1'b1;
                 if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
               end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // syncs idle high, blanking idle
      hs_q <= 1'b1;  vs_q <= 1'b1;  blank_q <= 1'b0;
      r_q <= '0;  g_q <= '0;  b_q <= '0;
      hs_prev_q <= 1'b1;  vs_prev_q <= 1'b1;
      hcnt_q <= '0;  lcnt_q <= '0;  xcnt_q <= '0;  ycnt_q <= '0;
      line_active_q <= 1'b0;
      state_q <= SEARCH;  good_cnt_q <= '0;
      x_q <= '0;  y_q <= '0;  pv_q <= 1'b0;
      pix_r_q <= '0;  pix_g_q <= '0;  pix_b_q <= '0;
      fs_q <= 1'b0;  locked_q <= 1'b0;  sync_err_q <= 1'b0;  err_count_q <= '0;
      h_meas_q <= '0;  v_meas_q <= '0;
    end else begin
      hs_q <= hs_d;  vs_q <= vs_d;  blank_q <= blank_d;
      r_q <= r_d;  g_q <= g_d;  b_q <= b_d;
      hs_prev_q <= hs_prev_d;  vs_prev_q <= vs_prev_d;
      hcnt_q <= hcnt_d;  lcnt_q <= lcnt_d;  xcnt_q <= xcnt_d;  ycnt_q <= ycnt_d;
      line_active_q <= line_active_d;
      state_q <= state_d;  good_cnt_q <= good_cnt_d;
      x_q <= x_d;  y_q <= y_d;  pv_q <= pv_d;
      pix_r_q <= pix_r_d;  pix_g_q <= pix_g_d;  pix_b_q <= pix_b_d;
      fs_q <= fs_d;  locked_q <= locked_d;  sync_err_q <= sync_err_d;  err_count_q <= err_count_d;
      h_meas_q <= h_meas_d;  v_meas_q <= v_meas_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = pv_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;
  assign sync_err    = sync_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Testbench for vga_sync_receiver using a reduced video mode (40 clk x 12 lines,
// 24x8 active) so that many frames fit in a short run. Expected pixel data and
// coordinates come from the frame geometry; lock/error behaviour is checked at
// frame boundaries.
module tb_vga_sync_receiver;
  localparam int HT     = 40;   // clocks per line
  localparam int VT     = 12;   // lines per frame
  localparam int HS_W   = 6;    // hsync low width (columns 0..5)
  localparam int HACT0  = 12;   // first active column
  localparam int HACT   = 24;
  localparam int VS_LN  = 2;    // vsync low length in lines
  localparam int VACT0  = 3;    // first active line
  localparam int VACT   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sh = 1'b1, sv = 1'b1, sb = 1'b0;
  logic [7:0] rr = '0, gg = '0, bb = '0;
  logic [9:0] x, y, h_meas, v_meas;
  logic       pixel_valid, frame_start, locked, sync_err;
  logic [7:0] pix_r, pix_g, pix_b, err_count;

  vga_sync_receiver #(.HTOTAL(HT), .VTOTAL(VT), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .SYNC_H(sh), .SYNC_V(sv), .SYNC_BLANK(sb),
    .Red(rr), .Green(gg), .Blue(bb),
    .x(x), .y(y), .pixel_valid(pixel_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked),
    .h_meas(h_meas), .v_meas(v_meas),
    .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int pv_cnt = 0, err_pulses = 0;
  // expectation for the sample driven on the previous step
  logic       e_valid = 1'b0, e_fs = 1'b0, e_chk = 1'b0;
  logic [9:0] e_x = '0, e_y = '0;
  logic [7:0] e_r = '0, e_g = '0, e_b = '0;
  logic       prev_v = 1'b1;
  logic       geo_ok = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix"},  32'({pixel_valid, x, y}), 32'd0);
    check({tag, "_rgb"},  32'({pix_r, pix_g, pix_b}), 32'd0);
    check({tag, "_sync"}, 32'({frame_start, locked, sync_err, err_count}), 32'd0);
    check({tag, "_meas"}, 32'({h_meas, v_meas}), 32'd0);
  endtask

  // One pixel clock: drive a sample, then check the outputs, which describe
  // the sample driven one step earlier (2 clk total latency).
  task automatic step(input logic h, input logic v, input logic b,
                      input logic [9:0] px, input logic [9:0] py);
    @(negedge clk);
    sh = h;  sv = v;  sb = b;
    rr = 8'($urandom);  gg = 8'($urandom);  bb = 8'($urandom);
    @(posedge clk);
    #1;
    check("pixel_valid", 32'(pixel_valid), 32'(e_valid));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    if (e_valid && e_chk) begin
      check("x", 32'(x), 32'(e_x));
      check("y", 32'(y), 32'(e_y));
      check("rgb", 32'({pix_r, pix_g, pix_b}), 32'({e_r, e_g, e_b}));
    end
    if (pixel_valid) pv_cnt++;
    if (sync_err) err_pulses++;
    e_valid = b;  e_fs = prev_v & ~v;  prev_v = v;
    e_x = px;  e_y = py;  e_r = rr;  e_g = gg;  e_b = bb;  e_chk = geo_ok;
  endtask

  // Vsync is low for VS_LN lines starting voff clocks after the line-0 hsync fall.
  task automatic drive_line(input int line, input int voff, input int ncols);
    int t;
    logic h, v, b;
    for (int c = 0; c < ncols; c++) begin
      t = line * HT + c;
      h = (c >= HS_W);
      v = !(t >= voff && t < VS_LN * HT + voff);
      b = (c >= HACT0 && c < HACT0 + HACT && line >= VACT0 && line < VACT0 + VACT);
      step(h, v, b, 10'(c - HACT0), 10'(line - VACT0));
    end
  endtask

  // Drive lines 0..last_line of a frame; short_line (if in range) is one clock short.
  task automatic drive_frame(input int voff, input int short_line, input int last_line,
                             input logic full);
    geo_ok = 1'b1;  pv_cnt = 0;  err_pulses = 0;
    for (int l = 0; l <= last_line; l++)
      drive_line(l, voff, (l == short_line) ? HT - 1 : HT);
    if (full) begin
      check("pixels_per_frame", 32'(pv_cnt), 32'(HACT * VACT));
      check("h_meas", 32'(h_meas), 32'(HT));
      check("v_meas", 32'(v_meas), 32'(VT));
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // acquire lock: WAIT_V after frame 0 hsync, LOCKING at frame 1 vsync,
    // locked at the vsync ending the second measured frame (frame 3 start)
    drive_frame(0, -1, VT - 1, 1'b0);
    check("locked_f0", 32'(locked), 32'd0);
    drive_frame(16, -1, VT - 1, 1'b1);
    check("locked_f1", 32'(locked), 32'd0);
    drive_frame(0, -1, VT - 1, 1'b1);
    check("locked_f2", 32'(locked), 32'd0);
    drive_frame(16, -1, VT - 1, 1'b1);
    check("locked_f3", 32'(locked), 32'd1);
    drive_frame(16 * int'($urandom_range(0, 1)), -1, VT - 1, 1'b1);
    check("locked_f4", 32'(locked), 32'd1);
    check("err_count_f4", 32'(err_count), 32'd0);

    // one 39-clock line while locked
    drive_frame(16 * int'($urandom_range(0, 1)), 5, VT - 1, 1'b1);
    check("short_err_pulses", 32'(err_pulses), 32'd1);
    check("short_err_count", 32'(err_count), 32'd1);
    check("short_locked", 32'(locked), 32'd0);
    drive_frame(16 * int'($urandom_range(0, 1)), -1, VT - 1, 1'b1);
    check("relock_f6", 32'(locked), 32'd0);
    drive_frame(16 * int'($urandom_range(0, 1)), -1, VT - 1, 1'b1);
    check("relock_f7", 32'(locked), 32'd0);
    drive_frame(0, -1, VT - 1, 1'b1);
    check("relock_f8", 32'(locked), 32'd1);

    // reset mid-line while locked
    drive_frame(0, -1, 4, 1'b0);
    drive_line(5, 0, 20);
    check("pre_reset_locked", 32'(locked), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    rst = 1'b1;
    e_valid = 1'b0;  e_fs = 1'b0;  prev_v = 1'b1;  geo_ok = 1'b0;

    // relock from fresh frames
    drive_frame(0, -1, VT - 1, 1'b0);
    drive_frame(16 * int'($urandom_range(0, 1)), -1, VT - 1, 1'b1);
    drive_frame(16 * int'($urandom_range(0, 1)), -1, VT - 1, 1'b1);
    check("rst_relock_f12", 32'(locked), 32'd0);
    drive_frame(0, -1, VT - 1, 1'b1);
    check("rst_relock_f13", 32'(locked), 32'd1);
    check("rst_err_count", 32'(err_count), 32'd0);

    // missing hsync: SYNC_H held high for 1100 clocks while locked
    drive_frame(0, -1, 2, 1'b0);
    err_pulses = 0;
    repeat (1100) step(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    check("hold_err_pulses", 32'(err_pulses), 32'd1);
    check("hold_err_count", 32'(err_count), 32'd1);
    check("hold_locked", 32'(locked), 32'd0);
    geo_ok = 1'b1;
    drive_line(0, 0, HT);
    check("hold_h_meas_sat", 32'(h_meas), 32'd1023);
    for (int l = 1; l < VT; l++) drive_line(l, 0, HT);
    drive_frame(16 * int'($urandom_range(0, 1)), -1, VT - 1, 1'b1);
    drive_frame(16 * int'($urandom_range(0, 1)), -1, VT - 1, 1'b1);
    check("hold_err_count_end", 32'(err_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
